seven_segment_scanner: RTL and testbench

- Parametrised successor to the fixed 4-digit multiplexed seven-segment driver.
- Generalises to N digits and derives its own refresh rate from a fast clock using an internal prescaler.
- Adds optional hex decode, per-digit decimal points, leading-zero blanking, PWM brightness, and a frame-coherent input snapshot.
- Sits between the score/game-state logic and the board's common-anode display pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/hex_to_segments.sv | 13 +
 rtl/seven_segment_scanner.sv | 152 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: the blank pattern,
// the active-low hex glyph table and the PWM on-time step helper.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the glyph for nibble n; bit7 (dp) is 1 (off) in every entry.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic int unsigned on_step(input int unsigned refresh_div,
                                            input int unsigned bright_width);
        return refresh_div >> bright_width;
    endfunction

endpackage

// File: rtl/hex_to_segments.sv
// Combinational hex nibble to active-low segment byte, with an
// active-high decimal point folded into bit7.
module hex_to_segments
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_segments
);

    assign o_segments = {~i_dp, HEX_SEG_TABLE[i_nibble][6:0]};

endmodule

// File: rtl/seven_segment_scanner.sv
// N-digit multiplexed common-anode display driver with prescaled refresh,
// frame-coherent input snapshot, hex decode, leading-zero blanking and PWM.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DIV_WIDTH    = 16,
    parameter int BRIGHT_WIDTH = 3
) (
    input  logic                      i_display_clk,
    input  logic                      i_rst_n,
    input  logic [N_DIGITS*8-1:0]     i_digits_raw,
    input  logic [N_DIGITS*4-1:0]     i_digits_hex,
    input  logic [N_DIGITS-1:0]       i_dp,
    input  logic                      i_mode,
    input  logic                      i_blank_lz,
    input  logic [BRIGHT_WIDTH-1:0]   i_brightness,
    output logic [7:0]                o_segments,
    output logic [N_DIGITS-1:0]       o_enables,
    output logic                      o_frame_start
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int ON_W  = DIV_WIDTH + 1;
    localparam int unsigned ON_STEP = on_step(REFRESH_DIV, BRIGHT_WIDTH);
    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_MSD  = IDX_W'(N_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [N_DIGITS*8-1:0]   r_snap_raw;
    logic [N_DIGITS*4-1:0]   r_snap_hex;
    logic [N_DIGITS-1:0]     r_snap_dp;
    logic                    r_snap_mode;
    logic                    r_snap_blz;
    logic [BRIGHT_WIDTH-1:0] r_snap_bright;
    logic [7:0]              r_segments;
    logic [N_DIGITS-1:0]     r_enables;
    logic                    r_frame_start;

    logic                    w_frame_edge;
    logic [N_DIGITS*8-1:0]   w_raw;
    logic [N_DIGITS*4-1:0]   w_hex;
    logic [N_DIGITS-1:0]     w_dp;
    logic                    w_mode;
    logic                    w_blz;
    logic [BRIGHT_WIDTH-1:0] w_bright;
    logic [7:0]              w_raw_sel;
    logic [3:0]              w_nib_sel;
    logic                    w_dp_sel;
    logic                    w_lz_sel;
    logic [N_DIGITS-1:0]     w_lz;
    logic [7:0]              w_hex_seg;
    logic [7:0]              w_pattern;
    logic [ON_W-1:0]         w_on_cnt;
    logic                    w_lit;
    logic                    w_show;
    logic [N_DIGITS-1:0]     w_en_lit;

    assign w_frame_edge = (r_cnt == '0) && (r_idx == IDX_MSD);

    // Bypass on the frame edge so the first slot already shows the new snapshot.
    assign w_raw    = w_frame_edge ? i_digits_raw : r_snap_raw;
    assign w_hex    = w_frame_edge ? i_digits_hex : r_snap_hex;
    assign w_dp     = w_frame_edge ? i_dp         : r_snap_dp;
    assign w_mode   = w_frame_edge ? i_mode       : r_snap_mode;
    assign w_blz    = w_frame_edge ? i_blank_lz   : r_snap_blz;
    assign w_bright = w_frame_edge ? i_brightness : r_snap_bright;

    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_lz         = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            v_zero_above = v_zero_above && (w_hex[4*i +: 4] == 4'h0);
            w_lz[i]      = v_zero_above && (i != 0);
        end
    end

    always_comb begin
        w_raw_sel = SEG_BLANK;
        w_nib_sel = 4'h0;
        w_dp_sel  = 1'b0;
        w_lz_sel  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_raw_sel = w_raw[8*i +: 8];
                w_nib_sel = w_hex[4*i +: 4];
                w_dp_sel  = w_dp[i];
                w_lz_sel  = w_lz[i];
            end
        end
    end

    hex_to_segments u_hex_to_segments (
        .i_nibble   (w_nib_sel),
        .i_dp       (w_dp_sel),
        .o_segments (w_hex_seg)
    );

    assign w_pattern = w_mode ? w_hex_seg : w_raw_sel;
    assign w_on_cnt  = ON_W'((int'(w_bright) + 1) * int'(ON_STEP));
    assign w_lit     = {1'b0, r_cnt} < w_on_cnt;
    assign w_show    = w_lit && !(w_mode && w_blz && w_lz_sel);
    assign w_en_lit  = ~(N_DIGITS'(1) << r_idx);

    always_ff @(posedge i_display_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt         <= '0;
            r_idx         <= IDX_MSD;
            r_snap_raw    <= '0;
            r_snap_hex    <= '0;
            r_snap_dp     <= '0;
            r_snap_mode   <= 1'b0;
            r_snap_blz    <= 1'b0;
            r_snap_bright <= '1;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == '0) ? IDX_MSD : r_idx - 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_frame_edge) begin
                r_snap_raw    <= i_digits_raw;
                r_snap_hex    <= i_digits_hex;
                r_snap_dp     <= i_dp;
                r_snap_mode   <= i_mode;
                r_snap_blz    <= i_blank_lz;
                r_snap_bright <= i_brightness;
            end
        end
    end

    always_ff @(posedge i_display_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_segments    <= SEG_BLANK;
            r_enables     <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_segments    <= w_show ? w_pattern : SEG_BLANK;
            r_enables     <= w_show ? w_en_lit : '1;
            r_frame_start <= w_frame_edge;
        end
    end

    assign o_segments    = r_segments;
    assign o_enables     = r_enables;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench: directed scenarios plus random inputs, compared each
// cycle against a cycle-count based model of the scan.
module tb_seven_segment_scanner;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int DW    = 4;
    localparam int BW    = 3;
    localparam int FRAME = N * RD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] raw   = 32'h11223344;
    logic [15:0] hex   = 16'h0000;
    logic [3:0]  dp    = 4'h0;
    logic        mode  = 1'b0;
    logic        blz   = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic [7:0]  seg;
    logic [3:0]  en;
    logic        fs;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    logic [31:0] m_raw, s_raw;
    logic [15:0] m_hex, s_hex;
    logic [3:0]  m_dp, s_dp;
    logic        m_mode, s_mode, m_blz, s_blz;
    logic [2:0]  m_bright, s_bright;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_segment_scanner #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (RD),
        .DIV_WIDTH    (DW),
        .BRIGHT_WIDTH (BW)
    ) dut (
        .i_display_clk (clk),
        .i_rst_n       (rst_n),
        .i_digits_raw  (raw),
        .i_digits_hex  (hex),
        .i_dp          (dp),
        .i_mode        (mode),
        .i_blank_lz    (blz),
        .i_brightness  (bright),
        .o_segments    (seg),
        .o_enables     (en),
        .o_frame_start (fs)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d after reset)", tag, got, exp, k);
        end
    endtask

    // Expected outputs for edge k after reset release, from slot arithmetic.
    task automatic model_out(output logic [7:0] e_seg, output logic [3:0] e_en, output logic e_fs);
        int cnt, idx, on;
        logic [7:0] pat;
        bit blank;
        cnt   = k % RD;
        idx   = N - 1 - ((k / RD) % N);
        e_fs  = ((k % FRAME) == 0);
        on    = (int'(m_bright) + 1) * (RD / (1 << BW));
        blank = m_mode && m_blz && (idx != 0) && ((m_hex >> (4 * idx)) == 16'h0);
        if (m_mode) begin
            pat = hex_tab[m_hex[4*idx +: 4]];
            if (m_dp[idx]) pat[7] = 1'b0;
        end else begin
            pat = m_raw[8*idx +: 8];
        end
        e_en = 4'hF;
        if (cnt < on && !blank) begin
            e_seg       = pat;
            e_en[idx]   = 1'b0;
        end else begin
            e_seg = 8'hFF;
        end
    endtask

    task automatic step();
        logic [7:0] e_seg;
        logic [3:0] e_en;
        logic       e_fs;
        s_raw = raw; s_hex = hex; s_dp = dp; s_mode = mode; s_blz = blz; s_bright = bright;
        @(posedge clk);
        #1;
        if ((k % FRAME) == 0) begin
            m_raw = s_raw; m_hex = s_hex; m_dp = s_dp;
            m_mode = s_mode; m_blz = s_blz; m_bright = s_bright;
        end
        model_out(e_seg, e_en, e_fs);
        check_val("segments",    32'(seg), 32'(e_seg));
        check_val("enables",     32'(en),  32'(e_en));
        check_val("frame_start", 32'(fs),  32'(e_fs));
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_segments"},    32'(seg), 32'hFF);
        check_val({tag, "_enables"},     32'(en),  32'hF);
        check_val({tag, "_frame_start"}, 32'(fs),  32'h0);
    endtask

    initial begin
        repeat (5) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;

        // Raw scan, then a mid-frame change that must wait for the next frame.
        run(FRAME + 10);
        raw = 32'h55667788;
        run(FRAME - 10 + FRAME);

        mode = 1'b1; hex = 16'h12AF; dp = 4'b0100;
        run(2 * FRAME);

        blz = 1'b1; hex = 16'h0007; dp = 4'b1111;
        run(2 * FRAME);
        hex = 16'h0000;
        run(2 * FRAME);

        mode = 1'b0; blz = 1'b0; bright = 3'd0; raw = 32'hA1B2C3D4;
        run(2 * FRAME);

        for (int i = 0; i < 16 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                raw    = $urandom;
                hex    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                dp     = 4'($urandom);
                mode   = 1'($urandom);
                blz    = 1'($urandom);
                bright = 3'($urandom);
            end
            step();
        end

        // Reset asserted mid-slot acts immediately; scan restarts at the MSD.
        run(13);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        mode = 1'b0; bright = 3'd7; raw = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
